snake_body_queue: RTL and testbench
===================================

# snake_body_queue

Upstream stage of the snake draw FSM. Holds the snake's segment coordinates in a circular buffer. On each move tick it computes the new head, checks for wall and self collisions, and issues pixel requests over a valid/ready handshake: erase the old tail, then draw the new head. The draw FSM consumes each request, plots one cell at (req_x, req_y), and asserts req_ready.

## Interface
- MAXLEN, 32: buffer depth in segments; power of 2.
- INIT_LEN, 4: segments drawn after reset; 2..MAXLEN.
- X0, 8'd39: initial head x.
- Y0, 7'd59: initial head y.
- XSCREEN, 160: screen width in cells.
- YSCREEN, 120: screen height in cells.

Ports:
- Clock  in  1  system clock (CLOCK_50 at top level); all logic on posedge.
- Reset  in  1  synchronous, active-high.
- step  in  1  one-cycle move tick; sampled only in IDLE.
- dir  in  2  requested direction: 00 up, 01 down, 10 left, 11 right; sampled with step.
- grow  in  1  food eaten on this move; sampled with step.
- req_valid  out  1  request pending.
- req_x  out  8  request cell x.
- req_y  out  7  request cell y.
- req_erase  out  1  1 = erase (background colour), 0 = draw (snake colour).
- req_ready  in  1  draw FSM accepts the request.
- busy  out  1  high in every state except IDLE.
- length  out  $clog2(MAXLEN)+1  current segment count.
- hit_wall  out  1  sticky wall collision.
- hit_self  out  1  sticky self collision.

## Operation
- States: INIT, IDLE, CALC, CHECK, TAIL, HEAD, DEAD.
- INIT:
  - Issues INIT_LEN draw requests, tail first: (X0-INIT_LEN+1+i, Y0) for i = 0..INIT_LEN-1.
  - Each accepted request writes the buffer and increments length.
  - Current direction becomes right.
  - Goes to IDLE after the last acceptance.
- IDLE:
  - On step, latch dir and grow, then go to CALC. Otherwise stay.
  - A dir opposite to the current direction is ignored; the current direction is kept.
- CALC: new head = current head ±1 on one axis, computed 1 bit wider than the coordinate.
  - If x < 0, x ≥ XSCREEN, y < 0 or y ≥ YSCREEN: set hit_wall and go to DEAD. No requests are issued.
  - Otherwise go to CHECK.
- CHECK: compares the new head against one buffer entry per cycle, walking from the head toward the tail.
  - Entries scanned: length (grow) or length-1 (no grow; the tail vacates).
  - On a match: set hit_self and go to DEAD.
  - When the scan completes: go to TAIL if not growing, else HEAD.
- TAIL: presents the tail coordinates with req_erase=1. On acceptance the tail pointer advances, then go to HEAD.
- HEAD: presents the new head with req_erase=0.
  - On acceptance the head pointer advances and the new head is written.
  - length increments if growing.
  - Then go to IDLE.
- grow is treated as 0 when length = MAXLEN, so length saturates at MAXLEN.
- DEAD: holds until Reset. step is ignored; req_valid stays 0.
- Pointers wrap modulo MAXLEN.

## Timing
- Reset values: req_valid=0, req_x=0, req_y=0, req_erase=0, length=0, hit_wall=0, hit_self=0, busy=1. State after reset is INIT.
- The first INIT request is valid 1 cycle after Reset deasserts.
- Handshake rules:
  - A transfer occurs on a cycle where req_valid and req_ready are both high.
  - Once req_valid is asserted, it and the payload stay stable until the transfer.
  - req_ready may be held high. The next request may be valid the cycle after a transfer.
- Latency from step (cycle 0, IDLE) to the first req_valid is 2 + N cycles, where N = number of entries scanned. With the macro off, N = 0.
- step arriving while busy is dropped; it is not queued.
- Reset asserted mid-operation abandons any pending request; req_valid=0 on the next cycle.
- The erase-before-draw order guarantees a head moving into the vacated tail cell ends up drawn.

## Configuration
- SNAKE_SELF_COLLISION_EN
  - Defined: the CHECK state scan runs as described.
  - Undefined: CHECK is bypassed (CALC goes straight to TAIL/HEAD), hit_self is tied to 0, and the compare logic is removed.

## Structure
- Package snake_pkg holds:
  - direction encodings DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT;
  - XSCREEN and YSCREEN;
  - coordinate widths XW=8 and YW=7;
  - the state encoding.
- Sub-module snake_seg_ram: MAXLEN × (XW+YW) storage with synchronous write and asynchronous read, shared by the tail output and the CHECK scan.

## Test plan
- Reset and INIT:
  - Stimulus: Reset, then req_ready held at 1.
  - Response: draws (36,59), (37,59), (38,59), (39,59) in order; length=4; busy falls.
- Plain move:
  - Stimulus: step, dir=11, grow=0.
  - Response: erase (36,59), then draw (40,59); length stays 4.
  - Macro on: first valid 5 cycles after step (N=3).
- Reversal and grow:
  - Reversal: step with dir=10 moves right anyway.
  - Grow: step with grow=1 gives no erase, one draw; length=5.
- Wall:
  - Stimulus: after Reset with X0=159, step dir=11.
  - Response: hit_wall=1, no request, step ignored thereafter.
- Self collision (macro on):
  - Stimulus: grow to length 5, then steps dir up, left, down.
  - Response: hit_self=1, no request.
- Backpressure and reset:
  - Backpressure: hold req_ready=0 for 10 cycles; payload is stable throughout.
  - Reset: assert Reset mid-request; req_valid=0 next cycle and INIT restarts.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake body queue.
// SNAKE_SELF_COLLISION_EN adds the CHECK-state body scan.
package snake_pkg;

    localparam int XW      = 8;
    localparam int YW      = 7;
    localparam int XSCREEN = 160;
    localparam int YSCREEN = 120;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_CALC,
        S_CHECK,
        S_TAIL,
        S_HEAD,
        S_DEAD
    } state_t;

    // Up/down and left/right share the high bit and differ in the low bit.
    function automatic logic is_opposite(dir_t a, dir_t b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

endpackage

// File: rtl/snake_body_queue_if.sv
// Pixel request channel from the body queue to the draw FSM.
interface snake_body_queue_if;
    import snake_pkg::*;

    logic          req_valid;
    logic [XW-1:0] req_x;
    logic [YW-1:0] req_y;
    logic          req_erase;
    logic          req_ready;

    modport master (output req_valid, output req_x, output req_y, output req_erase, input req_ready);
    modport slave  (input req_valid, input req_x, input req_y, input req_erase, output req_ready);

endinterface

// File: rtl/snake_seg_ram.sv
// Segment storage: synchronous write, asynchronous reads.
// The scan port exists only with SNAKE_SELF_COLLISION_EN.
module snake_seg_ram #(
    parameter int DEPTH = 32,
    parameter int W     = 15
) (
    input  logic                     CLOCK_50,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [W-1:0]             wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [W-1:0]             rd_data
`ifdef SNAKE_SELF_COLLISION_EN
    ,
    input  logic [$clog2(DEPTH)-1:0] scan_addr,
    output logic [W-1:0]             scan_data
`endif
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge CLOCK_50) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];
`ifdef SNAKE_SELF_COLLISION_EN
    assign scan_data = mem[scan_addr];
`endif

endmodule

// File: rtl/snake_body_queue.sv
// Snake body circular buffer: moves the head, detects collisions, emits erase/draw requests.
// SNAKE_SELF_COLLISION_EN enables the self-collision scan; otherwise hit_self is 0.
module snake_body_queue #(
    parameter int                       MAXLEN   = 32,
    parameter int                       INIT_LEN = 4,
    parameter logic [snake_pkg::XW-1:0] X0       = 8'd39,
    parameter logic [snake_pkg::YW-1:0] Y0       = 7'd59,
    parameter int                       XSCREEN  = 160,
    parameter int                       YSCREEN  = 120
) (
    input  logic                      CLOCK_50,
    input  logic                      Reset,
    input  logic                      step,
    input  logic [1:0]                dir,
    input  logic                      grow,
    snake_body_queue_if.master        req,
    output logic                      busy,
    output logic [$clog2(MAXLEN):0]   length,
    output logic                      hit_wall,
    output logic                      hit_self
);
    import snake_pkg::*;

    localparam int PW = $clog2(MAXLEN);
    localparam int LW = PW + 1;
    localparam int SW = XW + YW;
    localparam logic [XW-1:0] FIRST_X = X0 - XW'(INIT_LEN - 1);

    state_t        state, state_n;
    dir_t          cur_dir, cur_dir_n;
    logic          grow_lat, grow_lat_n;
    logic [PW-1:0] head_ptr, head_ptr_n, tail_ptr, tail_ptr_n, init_cnt, init_cnt_n;
    logic [XW-1:0] head_x, head_x_n, new_x, new_x_n, req_x_n;
    logic [YW-1:0] head_y, head_y_n, new_y, new_y_n, req_y_n;
    logic [LW-1:0] length_n;
    logic          req_valid_n, req_erase_n, hit_wall_n;
    logic          wr_en, xfer, do_launch;
    logic [PW-1:0] wr_addr;
    logic [SW-1:0] wr_data, tail_data;
    logic [XW:0]   calc_x;
    logic [YW:0]   calc_y;
    logic [XW-1:0] launch_x;
    logic [YW-1:0] launch_y;
`ifdef SNAKE_SELF_COLLISION_EN
    logic [PW-1:0] scan_ptr, scan_ptr_n;
    logic [LW-1:0] scan_cnt, scan_cnt_n;
    logic [SW-1:0] scan_data;
    logic          hit_self_n;
`endif

    snake_seg_ram #(.DEPTH(MAXLEN), .W(SW)) u_ram (
        .CLOCK_50  (CLOCK_50),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (tail_ptr),
        .rd_data   (tail_data)
`ifdef SNAKE_SELF_COLLISION_EN
        ,
        .scan_addr (scan_ptr),
        .scan_data (scan_data)
`endif
    );

    assign xfer = req.req_valid && req.req_ready;
    assign busy = (state != S_IDLE);

    // Candidate head one bit wider so stepping below zero wraps past the screen limit.
    always_comb begin
        calc_x = {1'b0, head_x};
        calc_y = {1'b0, head_y};
        case (cur_dir)
            DIR_UP:    calc_y = {1'b0, head_y} - (YW+1)'(1);
            DIR_DOWN:  calc_y = {1'b0, head_y} + (YW+1)'(1);
            DIR_LEFT:  calc_x = {1'b0, head_x} - (XW+1)'(1);
            default:   calc_x = {1'b0, head_x} + (XW+1)'(1);
        endcase
    end

    assign launch_x = (state == S_CALC) ? calc_x[XW-1:0] : new_x;
    assign launch_y = (state == S_CALC) ? calc_y[YW-1:0] : new_y;

    always_comb begin
        state_n     = state;
        cur_dir_n   = cur_dir;
        grow_lat_n  = grow_lat;
        head_ptr_n  = head_ptr;
        tail_ptr_n  = tail_ptr;
        init_cnt_n  = init_cnt;
        head_x_n    = head_x;
        head_y_n    = head_y;
        new_x_n     = new_x;
        new_y_n     = new_y;
        length_n    = length;
        hit_wall_n  = hit_wall;
        req_valid_n = req.req_valid;
        req_x_n     = req.req_x;
        req_y_n     = req.req_y;
        req_erase_n = req.req_erase;
        wr_en       = 1'b0;
        wr_addr     = head_ptr + PW'(1);
        wr_data     = {new_x, new_y};
        do_launch   = 1'b0;
`ifdef SNAKE_SELF_COLLISION_EN
        scan_ptr_n  = scan_ptr;
        scan_cnt_n  = scan_cnt;
        hit_self_n  = hit_self;
`endif
        case (state)
            S_INIT: begin
                if (!req.req_valid) begin
                    req_valid_n = 1'b1;
                    req_x_n     = FIRST_X;
                    req_y_n     = Y0;
                    req_erase_n = 1'b0;
                end else if (xfer) begin
                    wr_en      = 1'b1;
                    wr_addr    = init_cnt;
                    wr_data    = {req.req_x, req.req_y};
                    head_ptr_n = init_cnt;
                    head_x_n   = req.req_x;
                    head_y_n   = req.req_y;
                    length_n   = length + LW'(1);
                    if (init_cnt == PW'(INIT_LEN - 1)) begin
                        req_valid_n = 1'b0;
                        state_n     = S_IDLE;
                    end else begin
                        init_cnt_n = init_cnt + PW'(1);
                        req_x_n    = req.req_x + XW'(1);
                    end
                end
            end
            S_IDLE: begin
                if (step) begin
                    cur_dir_n  = is_opposite(dir_t'(dir), cur_dir) ? cur_dir : dir_t'(dir);
                    grow_lat_n = grow && (length != LW'(MAXLEN));
                    state_n    = S_CALC;
                end
            end
            S_CALC: begin
                if (calc_x >= (XW+1)'(XSCREEN) || calc_y >= (YW+1)'(YSCREEN)) begin
                    hit_wall_n = 1'b1;
                    state_n    = S_DEAD;
                end else begin
                    new_x_n = calc_x[XW-1:0];
                    new_y_n = calc_y[YW-1:0];
`ifdef SNAKE_SELF_COLLISION_EN
                    // The tail cell vacates on a plain move, so it is excluded from the scan.
                    scan_ptr_n = head_ptr;
                    scan_cnt_n = grow_lat ? length : length - LW'(1);
                    state_n    = S_CHECK;
`else
                    do_launch  = 1'b1;
`endif
                end
            end
`ifdef SNAKE_SELF_COLLISION_EN
            S_CHECK: begin
                if (scan_data == {new_x, new_y}) begin
                    hit_self_n = 1'b1;
                    state_n    = S_DEAD;
                end else begin
                    scan_ptr_n = scan_ptr - PW'(1);
                    scan_cnt_n = scan_cnt - LW'(1);
                    if (scan_cnt == LW'(1))
                        do_launch = 1'b1;
                end
            end
`endif
            S_TAIL: begin
                if (xfer) begin
                    tail_ptr_n  = tail_ptr + PW'(1);
                    req_x_n     = new_x;
                    req_y_n     = new_y;
                    req_erase_n = 1'b0;
                    state_n     = S_HEAD;
                end
            end
            S_HEAD: begin
                if (xfer) begin
                    wr_en       = 1'b1;
                    head_ptr_n  = head_ptr + PW'(1);
                    head_x_n    = new_x;
                    head_y_n    = new_y;
                    if (grow_lat)
                        length_n = length + LW'(1);
                    req_valid_n = 1'b0;
                    state_n     = S_IDLE;
                end
            end
            default: ;
        endcase

        // Erase the old tail first unless growing, so a head entering the vacated cell stays drawn.
        if (do_launch) begin
            req_valid_n = 1'b1;
            if (grow_lat) begin
                req_x_n     = launch_x;
                req_y_n     = launch_y;
                req_erase_n = 1'b0;
                state_n     = S_HEAD;
            end else begin
                req_x_n     = tail_data[SW-1:YW];
                req_y_n     = tail_data[YW-1:0];
                req_erase_n = 1'b1;
                state_n     = S_TAIL;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state         <= S_INIT;
            cur_dir       <= DIR_RIGHT;
            grow_lat      <= 1'b0;
            head_ptr      <= '0;
            tail_ptr      <= '0;
            init_cnt      <= '0;
            head_x        <= '0;
            head_y        <= '0;
            new_x         <= '0;
            new_y         <= '0;
            length        <= '0;
            hit_wall      <= 1'b0;
            req.req_valid <= 1'b0;
            req.req_x     <= '0;
            req.req_y     <= '0;
            req.req_erase <= 1'b0;
        end else begin
            state         <= state_n;
            cur_dir       <= cur_dir_n;
            grow_lat      <= grow_lat_n;
            head_ptr      <= head_ptr_n;
            tail_ptr      <= tail_ptr_n;
            init_cnt      <= init_cnt_n;
            head_x        <= head_x_n;
            head_y        <= head_y_n;
            new_x         <= new_x_n;
            new_y         <= new_y_n;
            length        <= length_n;
            hit_wall      <= hit_wall_n;
            req.req_valid <= req_valid_n;
            req.req_x     <= req_x_n;
            req.req_y     <= req_y_n;
            req.req_erase <= req_erase_n;
        end
    end

`ifdef SNAKE_SELF_COLLISION_EN
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            scan_ptr <= '0;
            scan_cnt <= '0;
            hit_self <= 1'b0;
        end else begin
            scan_ptr <= scan_ptr_n;
            scan_cnt <= scan_cnt_n;
            hit_self <= hit_self_n;
        end
    end
`else
    assign hit_self = 1'b0;
`endif

endmodule

// File: tb/tb_snake_body_queue.sv
// Scoreboard bench for snake_body_queue; covers both SNAKE_SELF_COLLISION_EN builds.
module tb_snake_body_queue;
    import snake_pkg::*;

`ifdef SNAKE_SELF_COLLISION_EN
    localparam int SC = 1;
`else
    localparam int SC = 0;
`endif

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic       erase;
    } req_t;

    logic       CLOCK_50 = 1'b0;
    logic       reset_a, reset_b, step_a, step_b, grow_a, grow_b;
    logic [1:0] dir_a, dir_b;
    logic       busy_a, busy_b, hit_wall_a, hit_wall_b, hit_self_a, hit_self_b;
    logic [5:0] length_a, length_b;
    req_t       exp_a[$];
    req_t       exp_b[$];
    int         checks = 0;
    int         errors = 0;
    logic       stall_a = 1'b0;
    req_t       held_a;

    snake_body_queue_if bus_a();
    snake_body_queue_if bus_b();

    always #5 CLOCK_50 = ~CLOCK_50;

    snake_body_queue #(.MAXLEN(32), .INIT_LEN(4), .X0(8'd39), .Y0(7'd59), .XSCREEN(160), .YSCREEN(120)) dut_a (
        .CLOCK_50(CLOCK_50), .Reset(reset_a), .step(step_a), .dir(dir_a), .grow(grow_a), .req(bus_a),
        .busy(busy_a), .length(length_a), .hit_wall(hit_wall_a), .hit_self(hit_self_a));

    snake_body_queue #(.MAXLEN(32), .INIT_LEN(4), .X0(8'd159), .Y0(7'd59), .XSCREEN(160), .YSCREEN(120)) dut_b (
        .CLOCK_50(CLOCK_50), .Reset(reset_b), .step(step_b), .dir(dir_b), .grow(grow_b), .req(bus_b),
        .busy(busy_b), .length(length_b), .hit_wall(hit_wall_b), .hit_self(hit_self_b));

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Monitor: pops one expectation per transfer and checks payload stays put under backpressure.
    always @(negedge CLOCK_50) begin
        if (reset_a) begin
            stall_a = 1'b0;
        end else begin
            if (stall_a) begin
                checkOutput("hold_valid", 32'(bus_a.req_valid), 32'd1);
                checkOutput("hold_payload", 32'({bus_a.req_x, bus_a.req_y, bus_a.req_erase}), 32'(held_a));
            end
            if (bus_a.req_valid && bus_a.req_ready) begin
                if (exp_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_req_a: got x=%0d y=%0d erase=%0d, required none",
                             bus_a.req_x, bus_a.req_y, bus_a.req_erase);
                end else begin
                    checkOutput("req_a", 32'({bus_a.req_x, bus_a.req_y, bus_a.req_erase}), 32'(exp_a.pop_front()));
                end
            end
            stall_a = bus_a.req_valid && !bus_a.req_ready;
            held_a  = {bus_a.req_x, bus_a.req_y, bus_a.req_erase};
        end
    end

    always @(negedge CLOCK_50) begin
        if (!reset_b && bus_b.req_valid && bus_b.req_ready) begin
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_req_b: got x=%0d y=%0d erase=%0d, required none",
                         bus_b.req_x, bus_b.req_y, bus_b.req_erase);
            end else begin
                checkOutput("req_b", 32'({bus_b.req_x, bus_b.req_y, bus_b.req_erase}), 32'(exp_b.pop_front()));
            end
        end
    end

    task automatic pushInit(input logic [7:0] x0, input logic which_b);
        for (int i = 0; i < 4; i++) begin
            if (which_b) exp_b.push_back('{x0 - 8'd3 + 8'(i), 7'd59, 1'b0});
            else         exp_a.push_back('{x0 - 8'd3 + 8'(i), 7'd59, 1'b0});
        end
    endtask

    task automatic waitIdleA(input string name);
        int n = 0;
        @(negedge CLOCK_50);
        while ((busy_a || exp_a.size() != 0) && n < 200) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got busy=%0d pending=%0d, required idle", name, busy_a, exp_a.size());
        end
        tick();
    endtask

    // Issues one step on dut_a and measures cycles from the step to the first req_valid.
    task automatic applyStimulus(input string name, input logic [1:0] d, input logic g, input int exp_lat);
        int lat = 1;
        step_a = 1'b1;
        dir_a  = d;
        grow_a = g;
        tick();
        step_a = 1'b0;
        grow_a = 1'b0;
        @(negedge CLOCK_50);
        while (!bus_a.req_valid && lat < 50) begin
            tick();
            lat++;
            @(negedge CLOCK_50);
        end
        checkOutput({name, "_latency"}, 32'(lat), 32'(exp_lat));
        waitIdleA(name);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_a = 1'b1; reset_b = 1'b1;
        step_a = 1'b0; step_b = 1'b0; grow_a = 1'b0; grow_b = 1'b0;
        dir_a = 2'b11; dir_b = 2'b11;
        bus_a.req_ready = 1'b1;
        bus_b.req_ready = 1'b1;
        repeat (3) tick();
        @(negedge CLOCK_50);
        checkOutput("rst_valid", 32'(bus_a.req_valid), 32'd0);
        checkOutput("rst_x", 32'(bus_a.req_x), 32'd0);
        checkOutput("rst_y", 32'(bus_a.req_y), 32'd0);
        checkOutput("rst_erase", 32'(bus_a.req_erase), 32'd0);
        checkOutput("rst_length", 32'(length_a), 32'd0);
        checkOutput("rst_hit_wall", 32'(hit_wall_a), 32'd0);
        checkOutput("rst_hit_self", 32'(hit_self_a), 32'd0);
        checkOutput("rst_busy", 32'(busy_a), 32'd1);
        tick();

        pushInit(8'd39, 1'b0);
        pushInit(8'd159, 1'b1);
        reset_a = 1'b0; reset_b = 1'b0;
        @(negedge CLOCK_50);
        checkOutput("init_valid_c0", 32'(bus_a.req_valid), 32'd0);
        tick();
        @(negedge CLOCK_50);
        checkOutput("init_valid_c1", 32'(bus_a.req_valid), 32'd1);
        waitIdleA("init");
        checkOutput("init_length", 32'(length_a), 32'd4);
        checkOutput("init_busy", 32'(busy_a), 32'd0);
        checkOutput("init_b_drained", 32'(exp_b.size()), 32'd0);

        // Wall: dut_b starts at the right edge and steps right.
        step_b = 1'b1;
        tick();
        step_b = 1'b0;
        repeat (6) tick();
        checkOutput("wall_hit", 32'(hit_wall_b), 32'd1);
        checkOutput("wall_busy", 32'(busy_b), 32'd1);
        step_b = 1'b1;
        tick();
        step_b = 1'b0;
        repeat (6) tick();
        checkOutput("wall_length", 32'(length_b), 32'd4);
        checkOutput("wall_valid", 32'(bus_b.req_valid), 32'd0);

        exp_a.push_back('{8'd36, 7'd59, 1'b1});
        exp_a.push_back('{8'd40, 7'd59, 1'b0});
        applyStimulus("plain", 2'b11, 1'b0, 2 + SC * 3);
        checkOutput("plain_length", 32'(length_a), 32'd4);

        exp_a.push_back('{8'd37, 7'd59, 1'b1});
        exp_a.push_back('{8'd41, 7'd59, 1'b0});
        applyStimulus("reverse", 2'b10, 1'b0, 2 + SC * 3);

        exp_a.push_back('{8'd42, 7'd59, 1'b0});
        applyStimulus("grow", 2'b11, 1'b1, 2 + SC * 4);
        checkOutput("grow_length", 32'(length_a), 32'd5);

        exp_a.push_back('{8'd38, 7'd59, 1'b1});
        exp_a.push_back('{8'd42, 7'd58, 1'b0});
        applyStimulus("up", 2'b00, 1'b0, 2 + SC * 4);

        exp_a.push_back('{8'd39, 7'd59, 1'b1});
        exp_a.push_back('{8'd41, 7'd58, 1'b0});
        applyStimulus("left", 2'b10, 1'b0, 2 + SC * 4);

`ifdef SNAKE_SELF_COLLISION_EN
        step_a = 1'b1; dir_a = 2'b01;
        tick();
        step_a = 1'b0;
        repeat (10) tick();
        checkOutput("self_hit", 32'(hit_self_a), 32'd1);
        checkOutput("self_busy", 32'(busy_a), 32'd1);
        checkOutput("self_valid", 32'(bus_a.req_valid), 32'd0);
`else
        exp_a.push_back('{8'd40, 7'd59, 1'b1});
        exp_a.push_back('{8'd41, 7'd59, 1'b0});
        applyStimulus("down", 2'b01, 1'b0, 2);
        checkOutput("down_hit_self", 32'(hit_self_a), 32'd0);
`endif

        // Backpressure during INIT; a step arriving while busy must be dropped.
        reset_a = 1'b1;
        bus_a.req_ready = 1'b0;
        repeat (2) tick();
        exp_a.delete();
        pushInit(8'd39, 1'b0);
        reset_a = 1'b0;
        for (int n = 0; n < 20 && !bus_a.req_valid; n++) tick();
        checkOutput("bp_valid", 32'(bus_a.req_valid), 32'd1);
        step_a = 1'b1;
        tick();
        step_a = 1'b0;
        repeat (9) tick();
        bus_a.req_ready = 1'b1;
        waitIdleA("bp_init");
        checkOutput("bp_length", 32'(length_a), 32'd4);

        // Reset while a tail erase is stalled.
        bus_a.req_ready = 1'b0;
        exp_a.push_back('{8'd36, 7'd59, 1'b1});
        step_a = 1'b1; dir_a = 2'b11;
        tick();
        step_a = 1'b0;
        for (int n = 0; n < 20 && !bus_a.req_valid; n++) tick();
        repeat (3) tick();
        checkOutput("stall_payload", 32'({bus_a.req_x, bus_a.req_y, bus_a.req_erase}), 32'({8'd36, 7'd59, 1'b1}));
        reset_a = 1'b1;
        tick();
        @(negedge CLOCK_50);
        checkOutput("reset_abandon", 32'(bus_a.req_valid), 32'd0);
        tick();
        exp_a.delete();
        pushInit(8'd39, 1'b0);
        reset_a = 1'b0;
        bus_a.req_ready = 1'b1;
        waitIdleA("reinit");
        checkOutput("reinit_length", 32'(length_a), 32'd4);
        checkOutput("reinit_busy", 32'(busy_a), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
